// File: rtl/assoc_cache_sequencer_pkg.sv
// seq_cache_pkg: shared types and width helpers for the cached program
// sequencer.
//   fsm_state_t   refill state machine encoding (ST_IDLE, ST_FILL)
//   idx_w()       index width of a power-of-two count (minimum 1 bit)
//   tag_w()       tag width left over after the set and offset fields
package seq_cache_pkg;

  typedef logic [0:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 1'b0;
  localparam fsm_state_t ST_FILL = 1'b1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int words);
    return addr_w - idx_w(sets) - idx_w(words);
  endfunction

endpackage

// File: rtl/assoc_cache_sequencer_if.sv
// assoc_cache_sequencer_if: branch controls in, fetch/refill signals out.
//   slave  modport: the sequencer (receives branch controls, drives the rest)
//   master modport: the pipeline/cache side driving branch controls
//   Branch: jump, conditional_jump, dont_jump_flag, jump_addr
//   Fetch:  pm_address, pc, hold_out, hit
//   Cache:  cache_rdway/rdline/rdoffset, cache_wrway/wrline/wroffset, cache_wren
//   Refill: rom_address; stats: miss_count
interface assoc_cache_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int JUMP_W = 4,
  parameter int SETS   = 4,
  parameter int WORDS  = 8
);
  import seq_cache_pkg::*;

  localparam int SET_W = idx_w(SETS);
  localparam int OFF_W = idx_w(WORDS);

  logic              jump;
  logic              conditional_jump;
  logic              dont_jump_flag;
  logic [JUMP_W-1:0] jump_addr;
  logic [ADDR_W-1:0] pm_address;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rom_address;
  logic              cache_rdway;
  logic              cache_wrway;
  logic [SET_W-1:0]  cache_rdline;
  logic [SET_W-1:0]  cache_wrline;
  logic [OFF_W-1:0]  cache_rdoffset;
  logic [OFF_W-1:0]  cache_wroffset;
  logic              cache_wren;
  logic              hold_out;
  logic              hit;
  logic [15:0]       miss_count;

  modport slave (
    input  jump, conditional_jump, dont_jump_flag, jump_addr,
    output pm_address, pc, rom_address, cache_rdway, cache_wrway,
           cache_rdline, cache_wrline, cache_rdoffset, cache_wroffset,
           cache_wren, hold_out, hit, miss_count
  );

  modport master (
    output jump, conditional_jump, dont_jump_flag, jump_addr,
    input  pm_address, pc, rom_address, cache_rdway, cache_wrway,
           cache_rdline, cache_wrline, cache_rdoffset, cache_wroffset,
           cache_wren, hold_out, hit, miss_count
  );

endinterface

// File: rtl/assoc_cache_sequencer_tag_store.sv
// cache_tag_store: tag, valid and LRU state of a 2-way set-associative cache.
//   clk, reset_n            clock, async active-low reset (clears everything)
//   lookup_set/lookup_tag   address under lookup
//   hit_any/hit_way         lookup result and matching way
//   victim_way              first invalid way (way 0 first), else LRU way
//   alloc_*                 miss: write tag into victim, clear its valid bit
//   fill_*                  refill done: set valid, other way becomes LRU
//   touch_*                 hit: the other way becomes LRU
module cache_tag_store
  import seq_cache_pkg::*;
#(
  parameter int SETS  = 4,
  parameter int TAG_W = 3,
  localparam int SET_W = idx_w(SETS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [SET_W-1:0] lookup_set,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit_any,
  output logic             hit_way,
  output logic             victim_way,
  input  logic             alloc_en,
  input  logic [SET_W-1:0] alloc_set,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic             alloc_way,
  input  logic             fill_done,
  input  logic [SET_W-1:0] fill_set,
  input  logic             fill_way,
  input  logic             touch_en,
  input  logic [SET_W-1:0] touch_set,
  input  logic             touch_way
);

  logic [TAG_W-1:0] tags  [2][SETS];
  logic [SETS-1:0]  valid [2];
  logic [SETS-1:0]  lru;          // bit = index of the least recently used way
  logic             match0, match1;

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    match0     = 1'b0;
    match1     = 1'b0;
    victim_way = 1'b0;
    match0     = valid[0][lookup_set] && (tags[0][lookup_set] == lookup_tag);
    match1     = valid[1][lookup_set] && (tags[1][lookup_set] == lookup_tag);
    if (!valid[0][lookup_set])      victim_way = 1'b0;
    else if (!valid[1][lookup_set]) victim_way = 1'b1;
    else                            victim_way = lru[lookup_set];
  end

  assign hit_any = match0 | match1;
  assign hit_way = ~match0;

  // NOTE: the tag array is small and held in flops, so it is reset along with
  // valid/LRU; a RAM-based tag store would reset only the valid bits.
  // Sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < 2; w++) begin
        for (int s = 0; s < SETS; s++) begin
          tags[w][s] <= '0;
        end
        valid[w] <= '0;
      end
      lru <= '0;
    end else begin
      // alloc, fill_done and touch come from mutually exclusive FSM cycles
      if (alloc_en) begin
        tags[alloc_way][alloc_set]  <= alloc_tag;
        valid[alloc_way][alloc_set] <= 1'b0;
      end
      if (fill_done) begin
        valid[fill_way][fill_set] <= 1'b1;
        lru[fill_set]             <= ~fill_way;
      end
      if (touch_en) begin
        lru[touch_set] <= ~touch_way;
      end
    end
  end

endmodule

// File: rtl/assoc_cache_sequencer.sv
// assoc_cache_sequencer: program counter sequencer in front of a 2-way
// set-associative instruction cache refilled from a synchronous ROM.
//   clk, reset_n  clock, async active-low reset
//   bus (slave)   branch controls in; fetch address, pc, cache read/write
//                 controls, rom_address, hold_out, hit, miss_count out
// The tag check is done on pc (the address whose data is due now); the cache
// data read port is addressed by pm_address. A miss holds the pipeline for one
// allocate cycle plus WORDS refill cycles, then the same pc hits.
// Optional: define ASSOC_CACHE_PERF_CNT_EN for a saturating 16-bit miss
// counter; otherwise miss_count is constant zero.
module assoc_cache_sequencer
  import seq_cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int JUMP_W = 4,
  parameter int SETS   = 4,
  parameter int WORDS  = 8
) (
  input logic clk,
  input logic reset_n,
  assoc_cache_sequencer_if.slave bus
);

  localparam int SET_W = idx_w(SETS);
  localparam int OFF_W = idx_w(WORDS);
  localparam int TAG_W = tag_w(ADDR_W, SETS, WORDS);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pm_next;
  logic [ADDR_W-1:0] target;
  fsm_state_t        state_q;
  logic [OFF_W-1:0]  fill_cnt_q;
  logic              victim_q;
  logic [OFF_W-1:0]  rom_off;

  logic [SET_W-1:0]  pc_set;
  logic [TAG_W-1:0]  pc_tag;
  logic              hit_any, hit_way, victim_way;
  logic              idle, hit, miss, hold, fill_last;

  assign pc_set = pc_q[OFF_W +: SET_W];
  assign pc_tag = pc_q[ADDR_W-1 -: TAG_W];

  assign idle      = (state_q == ST_IDLE);
  assign hit       = idle & hit_any;
  assign miss      = idle & ~hit_any;
  assign hold      = miss | ~idle;
  assign fill_last = ~idle && (fill_cnt_q == OFF_W'(WORDS - 1));

  cache_tag_store #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk        (clk),
    .reset_n    (reset_n),
    .lookup_set (pc_set),
    .lookup_tag (pc_tag),
    .hit_any    (hit_any),
    .hit_way    (hit_way),
    .victim_way (victim_way),
    .alloc_en   (miss),
    .alloc_set  (pc_set),
    .alloc_tag  (pc_tag),
    .alloc_way  (victim_way),
    .fill_done  (fill_last),
    .fill_set   (pc_set),
    .fill_way   (victim_q),
    .touch_en   (hit),
    .touch_set  (pc_set),
    .touch_way  (hit_way)
  );

  // Next fetch address; while held, pc stays put so the missed word is
  // re-read once the line is in, and branch inputs are ignored.
  always_comb begin
    target = '0;
    target[ADDR_W-1 -: JUMP_W] = bus.jump_addr;
    pm_next = pc_q + ADDR_W'(1);
    if (hold)                                         pm_next = pc_q;
    else if (bus.jump)                                pm_next = target;
    else if (bus.conditional_jump && !bus.dont_jump_flag) pm_next = target;
  end

  // ROM has one cycle of latency: request offset k+1 while writing offset k.
  always_comb begin
    rom_off = '0;
    if (!idle) rom_off = fill_cnt_q + OFF_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= '0;
      state_q    <= ST_IDLE;
      fill_cnt_q <= '0;
      victim_q   <= 1'b0;
    end else begin
      pc_q <= pm_next;
      case (state_q)
        ST_IDLE: begin
          if (miss) begin
            state_q    <= ST_FILL;
            fill_cnt_q <= '0;
            victim_q   <= victim_way;
          end
        end
        default: begin
          fill_cnt_q <= fill_cnt_q + OFF_W'(1);
          if (fill_last) state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ASSOC_CACHE_PERF_CNT_EN
  logic [15:0] miss_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_cnt_q <= '0;
    end else if (miss && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign bus.miss_count = miss_cnt_q;
`else
  assign bus.miss_count = '0;
`endif

  assign bus.pm_address     = pm_next;
  assign bus.pc             = pc_q;
  assign bus.rom_address    = {pc_q[ADDR_W-1:OFF_W], rom_off};
  assign bus.cache_rdway    = hit_way;
  assign bus.cache_rdline   = pm_next[OFF_W +: SET_W];
  assign bus.cache_rdoffset = pm_next[OFF_W-1:0];
  assign bus.cache_wrway    = victim_q;
  assign bus.cache_wrline   = pc_set;
  assign bus.cache_wroffset = fill_cnt_q;
  assign bus.cache_wren     = ~idle;
  assign bus.hold_out       = hold;
  assign bus.hit            = hit;

endmodule

// File: tb/tb_assoc_cache_sequencer.sv
// Directed bench for assoc_cache_sequencer with default parameters:
// tag = addr[7:5], set = addr[4:3], offset = addr[2:0].
module tb_assoc_cache_sequencer;

  localparam int ADDR_W = 8;
  localparam int JUMP_W = 4;
  localparam int SETS   = 4;
  localparam int WORDS  = 8;

`ifdef ASSOC_CACHE_PERF_CNT_EN
  localparam logic [15:0] EXP_MISSES = 16'd4;
`else
  localparam logic [15:0] EXP_MISSES = 16'd0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  assoc_cache_sequencer_if #(
    .ADDR_W(ADDR_W), .JUMP_W(JUMP_W), .SETS(SETS), .WORDS(WORDS)
  ) bus ();

  assoc_cache_sequencer #(
    .ADDR_W(ADDR_W), .JUMP_W(JUMP_W), .SETS(SETS), .WORDS(WORDS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_jump(input logic [3:0] ja);
    bus.jump      = 1'b1;
    bus.jump_addr = ja;
    step();
    bus.jump      = 1'b0;
    #1;
  endtask

  task automatic wait_unheld(input string name);
    int n = 0;
    while (bus.hold_out === 1'b1 && n < 20) begin
      step();
      n++;
    end
    #1;
    total++;
    if (bus.hold_out !== 1'b0) begin
      bad++;
      $display("FAIL %s: hold_out still %b after %0d cycles, want 0", name, bus.hold_out, n);
    end
  endtask

  task automatic test_reset();
    reset_n              = 1'b0;
    bus.jump             = 1'b0;
    bus.conditional_jump = 1'b0;
    bus.dont_jump_flag   = 1'b0;
    bus.jump_addr        = '0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", bus.pc); end
    total++;
    if (bus.cache_wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", bus.cache_wren); end
    total++;
    if (bus.miss_count !== 16'd0) begin bad++; $display("FAIL reset_miss_count: got %0d want 0", bus.miss_count); end
    reset_n = 1'b1;
    #1;
    // Miss cycle (i=0) followed by eight refill cycles (i=1..8).
    for (int i = 0; i < 9; i++) begin
      total++;
      if (bus.hold_out !== 1'b1) begin bad++; $display("FAIL fill_hold[%0d]: got %b want 1", i, bus.hold_out); end
      if (i < 8) begin
        total++;
        if (bus.rom_address !== 8'(i)) begin bad++; $display("FAIL fill_rom[%0d]: got %h want %h", i, bus.rom_address, 8'(i)); end
      end
      total++;
      if (bus.cache_wren !== (i != 0)) begin bad++; $display("FAIL fill_wren[%0d]: got %b want %b", i, bus.cache_wren, (i != 0)); end
      if (i > 0) begin
        total++;
        if (bus.cache_wroffset !== 3'(i - 1)) begin bad++; $display("FAIL fill_wroffset[%0d]: got %0d want %0d", i, bus.cache_wroffset, i - 1); end
        total++;
        if (bus.cache_wrway !== 1'b0) begin bad++; $display("FAIL fill_wrway[%0d]: got %b want 0", i, bus.cache_wrway); end
      end
      step();
      #1;
    end
    total++;
    if (bus.hold_out !== 1'b0) begin bad++; $display("FAIL after_fill_hold: got %b want 0", bus.hold_out); end
    total++;
    if (bus.hit !== 1'b1 || bus.pc !== 8'h00 || bus.cache_rdway !== 1'b0) begin
      bad++; $display("FAIL after_fill_hit: hit=%b pc=%h way=%b want 1/00/0", bus.hit, bus.pc, bus.cache_rdway);
    end
    total++;
    if (bus.pm_address !== 8'h01) begin bad++; $display("FAIL after_fill_pm: got %h want 01", bus.pm_address); end
  endtask

  task automatic check_seq_hit(input logic [7:0] a);
    step();
    #1;
    total++;
    if (bus.pc !== a || bus.hit !== 1'b1 || bus.hold_out !== 1'b0) begin
      bad++; $display("FAIL seq_hit: pc=%h hit=%b hold=%b want %h/1/0", bus.pc, bus.hit, bus.hold_out, a);
    end
  endtask

  task automatic test_cond_jump();
    bus.conditional_jump = 1'b1;
    bus.dont_jump_flag   = 1'b1;
    bus.jump_addr        = 4'h2;
    #1;
    total++;
    if (bus.pm_address !== 8'h04) begin bad++; $display("FAIL cond_flag_set: got %h want 04", bus.pm_address); end
    bus.dont_jump_flag = 1'b0;
    #1;
    total++;
    if (bus.pm_address !== 8'h20) begin bad++; $display("FAIL cond_taken: got %h want 20", bus.pm_address); end
    bus.conditional_jump = 1'b0;
    #1;
    total++;
    if (bus.pm_address !== 8'h04) begin bad++; $display("FAIL cond_released: got %h want 04", bus.pm_address); end
  endtask

  task automatic test_jump();
    bus.jump      = 1'b1;
    bus.jump_addr = 4'h2;
    #1;
    total++;
    if (bus.pm_address !== 8'h20) begin bad++; $display("FAIL jump_pm: got %h want 20", bus.pm_address); end
    step();
    bus.jump = 1'b0;
    #1;
    total++;
    if (bus.pc !== 8'h20 || bus.hit !== 1'b0 || bus.hold_out !== 1'b1 || bus.rom_address !== 8'h20) begin
      bad++; $display("FAIL jump_miss: pc=%h hit=%b hold=%b rom=%h want 20/0/1/20", bus.pc, bus.hit, bus.hold_out, bus.rom_address);
    end
    step();
    #1;
    total++;
    if (bus.cache_wren !== 1'b1 || bus.cache_wrway !== 1'b1 || bus.cache_wroffset !== 3'd0 || bus.cache_wrline !== 2'd0) begin
      bad++; $display("FAIL jump_fill: wren=%b way=%b off=%0d line=%0d want 1/1/0/0", bus.cache_wren, bus.cache_wrway, bus.cache_wroffset, bus.cache_wrline);
    end
    wait_unheld("jump_fill_done");
    total++;
    if (bus.hit !== 1'b1 || bus.cache_rdway !== 1'b1 || bus.pc !== 8'h20) begin
      bad++; $display("FAIL jump_after_fill: hit=%b way=%b pc=%h want 1/1/20", bus.hit, bus.cache_rdway, bus.pc);
    end
    do_jump(4'h0);
    total++;
    if (bus.pc !== 8'h00 || bus.hit !== 1'b1 || bus.cache_rdway !== 1'b0 || bus.hold_out !== 1'b0) begin
      bad++; $display("FAIL jump_back_hit: pc=%h hit=%b way=%b hold=%b want 00/1/0/0", bus.pc, bus.hit, bus.cache_rdway, bus.hold_out);
    end
  endtask

  task automatic test_evict();
    do_jump(4'h4);
    total++;
    if (bus.pc !== 8'h40 || bus.hit !== 1'b0 || bus.hold_out !== 1'b1) begin
      bad++; $display("FAIL evict_miss: pc=%h hit=%b hold=%b want 40/0/1", bus.pc, bus.hit, bus.hold_out);
    end
    step();
    #1;
    total++;
    if (bus.cache_wrway !== 1'b1) begin bad++; $display("FAIL evict_victim_lru: got way %b want 1", bus.cache_wrway); end
    wait_unheld("evict_fill_done");
    total++;
    if (bus.hit !== 1'b1 || bus.cache_rdway !== 1'b1) begin
      bad++; $display("FAIL evict_hit: hit=%b way=%b want 1/1", bus.hit, bus.cache_rdway);
    end
    do_jump(4'h2);
    total++;
    if (bus.pc !== 8'h20 || bus.hit !== 1'b0 || bus.hold_out !== 1'b1) begin
      bad++; $display("FAIL evicted_remiss: pc=%h hit=%b hold=%b want 20/0/1", bus.pc, bus.hit, bus.hold_out);
    end
    step();
    #1;
    total++;
    if (bus.cache_wrway !== 1'b0) begin bad++; $display("FAIL remiss_victim: got way %b want 0", bus.cache_wrway); end
    wait_unheld("remiss_fill_done");
    total++;
    if (bus.hit !== 1'b1 || bus.cache_rdway !== 1'b0) begin
      bad++; $display("FAIL remiss_hit: hit=%b way=%b want 1/0", bus.hit, bus.cache_rdway);
    end
  endtask

  task automatic test_miss_count();
    total++;
    if (bus.miss_count !== EXP_MISSES) begin
      bad++; $display("FAIL miss_count: got %0d want %0d", bus.miss_count, EXP_MISSES);
    end
  endtask

  task automatic test_reset_mid_fill();
    do_jump(4'h6);
    for (int i = 0; i < 4; i++) step();
    #1;
    total++;
    if (bus.cache_wren !== 1'b1 || bus.cache_wroffset !== 3'd3) begin
      bad++; $display("FAIL midfill_pre: wren=%b off=%0d want 1/3", bus.cache_wren, bus.cache_wroffset);
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.pc !== 8'h00 || bus.cache_wren !== 1'b0 || bus.hit !== 1'b0 || bus.cache_wroffset !== 3'd0 || bus.miss_count !== 16'd0) begin
      bad++; $display("FAIL midfill_reset: pc=%h wren=%b hit=%b off=%0d cnt=%0d want 00/0/0/0/0",
                      bus.pc, bus.cache_wren, bus.hit, bus.cache_wroffset, bus.miss_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (bus.hold_out !== 1'b1 || bus.rom_address !== 8'h00 || bus.hit !== 1'b0) begin
      bad++; $display("FAIL midfill_refetch: hold=%b rom=%h hit=%b want 1/00/0", bus.hold_out, bus.rom_address, bus.hit);
    end
    step();
    #1;
    total++;
    if (bus.cache_wren !== 1'b1 || bus.cache_wroffset !== 3'd0 || bus.cache_wrway !== 1'b0) begin
      bad++; $display("FAIL midfill_restart: wren=%b off=%0d way=%b want 1/0/0", bus.cache_wren, bus.cache_wroffset, bus.cache_wrway);
    end
    wait_unheld("midfill_done");
    total++;
    if (bus.hit !== 1'b1 || bus.pc !== 8'h00) begin
      bad++; $display("FAIL midfill_hit: hit=%b pc=%h want 1/00", bus.hit, bus.pc);
    end
  endtask

  initial begin
    test_reset();
    for (int a = 1; a <= 3; a++) check_seq_hit(8'(a));
    test_cond_jump();
    for (int a = 4; a <= 7; a++) check_seq_hit(8'(a));
    test_jump();
    test_evict();
    test_miss_count();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/assoc_cache_sequencer.md
ASSOC_CACHE_SEQUENCER -- requirements
Module: assoc_cache_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-memory address width.
REQ-002 SHALL have parameter JUMP_W, default 4, jump target width; target = {jump_addr, zeros}.
REQ-003 SHALL have parameter SETS, default 4, cache sets (power of 2).
REQ-004 SHALL have parameter WORDS, default 8, words per line (power of 2); ways fixed at 2.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 jump, conditional_jump, dont_jump_flag  in  1 each  branch controls.
REQ-008 jump_addr  in  JUMP_W  branch target high bits.
REQ-009 pm_address, pc  out  ADDR_W  next fetch address / registered current address.
REQ-010 rom_address  out  ADDR_W  refill read address to synchronous ROM.
REQ-011 cache_rdway, cache_wrway  out  1  ways for read / refill write.
REQ-012 cache_rdline, cache_wrline  out  log2(SETS)  set indices; cache_rdoffset, cache_wroffset  out  log2(WORDS).
REQ-013 cache_wren, hold_out, hit  out  1  refill write strobe, pipeline stall, lookup hit.
REQ-014 miss_count  out  16  refill counter (see Configuration).

Function
REQ-015 pm_address SHALL be combinational, priority: hold_out -> pc; jump -> target; conditional_jump & !dont_jump_flag -> target; else pc+1 wrapping at 2^ADDR_W-1 -> 0.
REQ-016 pc SHALL register pm_address every cycle.
REQ-017 Address split: offset = low log2(WORDS) bits, set = next log2(SETS) bits, tag = remaining bits; cache_rdline/rdoffset SHALL come from pm_address.
REQ-018 hit SHALL be 1 when FSM is IDLE and either way of the set is valid with matching tag; cache_rdway = matching way.
REQ-019 FSM states IDLE, FILL; IDLE with miss -> FILL; FILL with last offset written -> IDLE.
REQ-020 Victim SHALL be first invalid way (way 0 priority), else LRU way of the set; on miss its tag SHALL be written and valid cleared.
REQ-021 In the miss cycle rom_address = {tag, set, 0}; in FILL cycle k (k=0..WORDS-1) cache_wren=1, cache_wroffset=k, rom_address offset=k+1 (ROM latency one cycle).
REQ-022 Last FILL cycle SHALL set victim valid and mark the other way LRU.
REQ-023 Each IDLE hit SHALL mark the non-hit way LRU of that set.
REQ-024 hold_out SHALL be 1 in the miss cycle and all FILL cycles: WORDS+1 stall cycles per miss; branch inputs ignored while held.
REQ-025 Lookup in the cycle after FILL SHALL hit without stall.

Reset
REQ-026 reset_n low SHALL immediately clear pc, FSM (IDLE), fill counter, all valid and LRU bits, tags, miss_count; cache_wren=0.
REQ-027 Reset mid-FILL SHALL abandon the refill; partially written line remains invalid.
REQ-028 First fetch after release (0x00) SHALL miss and refill.

Configuration
REQ-029 Macro ASSOC_CACHE_PERF_CNT_EN defined: miss_count increments on each miss cycle, saturating at 0xFFFF; undefined: miss_count tied to 0 and no counter logic.

Structure
REQ-030 Package seq_cache_pkg SHALL hold FSM state typedef and index/tag width helper functions.
REQ-031 Sub-module cache_tag_store SHALL hold tags, valid and LRU arrays with lookup/victim outputs.

Verification (defaults; tag=[7:5], set=[4:3], offset=[2:0])
REQ-032 Reset release -> hold_out 9 cycles, rom_address 0x00..0x07, cache_wren offsets 0..7 way 0; then 0x01..0x07 hit, no stall.
REQ-033 jump, jump_addr=2 (0x20) -> miss set 0, fill way 1; jump_addr=0 -> 0x00 hits way 0, no stall.
REQ-034 Then jump to 0x40 -> evicts way 1 (LRU); jump to 0x20 -> misses again.
REQ-035 conditional_jump=1, dont_jump_flag=1 at pc=0x03 -> pm_address 0x04; flag=0 -> 0x20.
REQ-036 reset_n low during FILL offset 3 -> all outputs reset same cycle; after release 0x00 refetched from offset 0.
REQ-037 With ASSOC_CACHE_PERF_CNT_EN, after REQ-032..034 miss_count=4; without, 0.
